// File: rtl/mem_access_stage_if.sv
// mem_access_stage_if: execute-side, data-memory and write-back signals of the memory stage
interface mem_access_stage_if #(
  parameter int DWIDTH = 32,
  parameter int RWIDTH = 5
);
  logic              ex_valid;
  logic              ex_ready;
  logic              flush;
  logic [DWIDTH-1:0] alu_out;
  logic [DWIDTH-1:0] store_data;
  logic [1:0]        mem_fcn;
  logic [2:0]        mem_typ;
  logic [RWIDTH-1:0] rd_addr;
  logic              rf_wen;
  logic              dmem_req;
  logic              dmem_we;
  logic [DWIDTH-1:0] dmem_addr;
  logic [3:0]        dmem_be;
  logic [DWIDTH-1:0] dmem_wdata;
  logic              dmem_gnt;
  logic              dmem_rvalid;
  logic [DWIDTH-1:0] dmem_rdata;
  logic              wb_valid;
  logic              wb_wen;
  logic [RWIDTH-1:0] wb_rd;
  logic [DWIDTH-1:0] wb_data;
  logic              misalign_exc;
  modport slave (
    input  ex_valid, flush, alu_out, store_data, mem_fcn, mem_typ, rd_addr, rf_wen,
           dmem_gnt, dmem_rvalid, dmem_rdata,
    output ex_ready, dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
           wb_valid, wb_wen, wb_rd, wb_data, misalign_exc
  );
  modport master (
    output ex_valid, flush, alu_out, store_data, mem_fcn, mem_typ, rd_addr, rf_wen,
           dmem_gnt, dmem_rvalid, dmem_rdata,
    input  ex_ready, dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
           wb_valid, wb_wen, wb_rd, wb_data, misalign_exc
  );
endinterface

// File: rtl/mem_access_stage.sv
// mem_access_stage: load/store memory stage with byte lanes and load extension; MEM_MISALIGN_TRAP_EN traps misaligned H/W accesses
module mem_access_stage #(
  parameter int DWIDTH = 32,
  parameter int RWIDTH = 5
) (
  input logic clk,
  input logic reset_n,
  mem_access_stage_if.slave bus
);
  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;
  state_t            state;
  logic [DWIDTH-1:0] res;
  logic [RWIDTH-1:0] rd;
  logic [2:0]        typ;
  logic [1:0]        off;
  logic              wen, is_load, killed, trap;
  logic              in_mem, in_byte, in_half, mis;
  logic [1:0]        in_off;
  logic [3:0]        in_be;
  logic [DWIDTH-1:0] in_wdata, w, ld_val;
  assign in_mem   = bus.mem_fcn == 2'b01 || bus.mem_fcn == 2'b10;
  assign in_byte  = bus.mem_typ[1:0] == 2'b00;
  assign in_half  = bus.mem_typ[1:0] == 2'b01;
  assign in_off   = in_byte ? bus.alu_out[1:0] : in_half ? {bus.alu_out[1], 1'b0} : 2'b00;
  assign in_be    = in_byte ? 4'b0001 << bus.alu_out[1:0] : in_half ? 4'b0011 << {bus.alu_out[1], 1'b0} : 4'b1111;
  assign in_wdata = in_byte ? {4{bus.store_data[7:0]}} : in_half ? {2{bus.store_data[15:0]}} : bus.store_data;
`ifdef MEM_MISALIGN_TRAP_EN
  assign mis = in_mem && ((in_half && bus.alu_out[0]) || (!in_byte && !in_half && bus.alu_out[1:0] != 2'b00));
`else
  assign mis = 1'b0;
`endif
  // load data is shifted so the addressed lane lands at bit 0, then extended per the latched type
  assign w        = bus.dmem_rdata >> {off, 3'b000};
  assign ld_val   = typ[1:0] == 2'b00 ? {{24{w[7] & ~typ[2]}}, w[7:0]} :
                    typ[1:0] == 2'b01 ? {{16{w[15] & ~typ[2]}}, w[15:0]} : bus.dmem_rdata;
  assign bus.ex_ready = state == IDLE;
  // operation FSM: issue, wait for grant, wait for load data, then a single write-back pulse
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state            <= IDLE;
      bus.dmem_req     <= 1'b0;
      bus.dmem_we      <= 1'b0;
      bus.dmem_addr    <= '0;
      bus.dmem_be      <= 4'b0000;
      bus.dmem_wdata   <= '0;
      bus.wb_valid     <= 1'b0;
      bus.wb_wen       <= 1'b0;
      bus.wb_rd        <= '0;
      bus.wb_data      <= '0;
      bus.misalign_exc <= 1'b0;
      res              <= '0;
      rd               <= '0;
      typ              <= 3'b000;
      off              <= 2'b00;
      wen              <= 1'b0;
      is_load          <= 1'b0;
      killed           <= 1'b0;
      trap             <= 1'b0;
    end else begin
      bus.wb_valid     <= 1'b0;
      bus.wb_wen       <= 1'b0;
      bus.misalign_exc <= 1'b0;
      case (state)
        IDLE: if (bus.ex_valid && !bus.flush) begin
          state          <= in_mem && !mis ? REQ : DONE;
          bus.dmem_req   <= in_mem && !mis;
          bus.dmem_we    <= bus.mem_fcn == 2'b10;
          bus.dmem_addr  <= {bus.alu_out[DWIDTH-1:2], 2'b00};
          bus.dmem_be    <= bus.mem_fcn == 2'b10 ? in_be : 4'b1111;
          bus.dmem_wdata <= in_wdata;
          res            <= bus.alu_out;
          rd             <= bus.rd_addr;
          wen            <= bus.rf_wen && bus.mem_fcn != 2'b10 && !mis;
          typ            <= bus.mem_typ;
          off            <= in_off;
          is_load        <= bus.mem_fcn == 2'b01;
          killed         <= 1'b0;
          trap           <= mis;
        end
        REQ: if (bus.dmem_gnt) begin
          bus.dmem_req <= 1'b0;
          state        <= is_load ? WAIT : DONE;
          killed       <= bus.flush;
        end else if (bus.flush) begin
          bus.dmem_req <= 1'b0;
          state        <= IDLE;
        end
        WAIT: begin
          killed <= killed || bus.flush;
          if (bus.dmem_rvalid) begin
            res   <= ld_val;
            state <= DONE;
          end
        end
        DONE: begin
          bus.wb_valid     <= !killed && !bus.flush;
          bus.wb_wen       <= wen && !killed && !bus.flush;
          bus.misalign_exc <= trap && !killed && !bus.flush;
          bus.wb_rd        <= rd;
          bus.wb_data      <= res;
          state            <= IDLE;
        end
      endcase
    end
endmodule

// File: tb/tb_mem_access_stage.sv
// tb_mem_access_stage: randomized scoreboard bench for mem_access_stage (honours MEM_MISALIGN_TRAP_EN)
module tb_mem_access_stage;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int unsigned cyc = 0;
  int tests = 0;
  int fails = 0;
  typedef struct packed {
    logic [31:0] data;
    logic        dc;
    logic [4:0]  rd;
    logic        wen;
    logic        exc;
    logic [31:0] at;
  } exp_t;
  exp_t q[$];

  mem_access_stage_if bus();
  mem_access_stage dut (.clk(clk), .reset_n(reset_n), .bus(bus));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!bus.ex_ready && n < 30) begin
      @(negedge clk);
      n++;
    end
    chk("ready_timeout", {31'b0, bus.ex_ready}, 32'd1);
  endtask

  // fm: 0 normal, 1 flush in REQ before gnt, 2 flush in WAIT, 3 flush with same-cycle gnt
  task automatic do_op(input logic [1:0] fcn, input logic [2:0] typ, input logic [31:0] a,
                       input logic [31:0] sd, input logic [31:0] rdata, input logic [4:0] rd,
                       input logic w, input int gw, input int rw, input int fm);
    int sz, lo, eff, lat;
    bit mem, mis, sgn;
    longint unsigned v;
    logic [31:0] be, wd, d;
    exp_t e;
    sz  = (typ == 0 || typ == 4) ? 1 : (typ == 1 || typ == 5) ? 2 : 4;
    sgn = typ == 0 || typ == 1;
    lo  = int'(a % 4);
    eff = lo - lo % sz;
    mem = fcn == 1 || fcn == 2;
    mis = 0;
`ifdef MEM_MISALIGN_TRAP_EN
    mis = mem && (lo % sz != 0);
`endif
    v = (longint'(rdata) >> (8 * eff)) & ((64'd1 << (8 * sz)) - 1);
    if (sgn && v >= (64'd1 << (8 * sz - 1))) v = v - (64'd1 << (8 * sz));
    d   = (fcn == 1 && !mis) ? v[31:0] : a;
    be  = fcn == 2 ? ((32'd1 << sz) - 1) << eff : 32'hF;
    wd  = sz == 1 ? {24'b0, sd[7:0]} * 32'h0101_0101 : sz == 2 ? {16'b0, sd[15:0]} * 32'h0001_0001 : sd;
    lat = (!mem || mis) ? 2 : fcn == 2 ? 3 + gw : 4 + gw + rw;
    wait_ready();
    bus.ex_valid = 1'b1;
    bus.mem_fcn = fcn;
    bus.mem_typ = typ;
    bus.alu_out = a;
    bus.store_data = sd;
    bus.rd_addr = rd;
    bus.rf_wen = w;
    if (fm == 0) begin
      e.data = d;
      e.dc = fcn != 2 || mis;
      e.rd = rd;
      e.wen = w && fcn != 2 && !mis;
      e.exc = mis;
      e.at = cyc + lat;
      q.push_back(e);
    end
    @(negedge clk);
    bus.ex_valid = 1'b0;
    bus.alu_out = $urandom;
    bus.store_data = $urandom;
    if (mem && !mis) begin
      chk("dmem_req", {31'b0, bus.dmem_req}, 32'd1);
      chk("dmem_we", {31'b0, bus.dmem_we}, {31'b0, fcn == 2});
      chk("dmem_addr", bus.dmem_addr, a & ~32'd3);
      chk("dmem_be", {28'b0, bus.dmem_be}, be);
      if (fcn == 2) chk("dmem_wdata", bus.dmem_wdata, wd);
      if (fm == 1) begin
        bus.flush = 1'b1;
        @(negedge clk);
        bus.flush = 1'b0;
        chk("flush_req_drop", {31'b0, bus.dmem_req}, 32'd0);
        chk("flush_ready", {31'b0, bus.ex_ready}, 32'd1);
      end else begin
        for (int i = 0; i < gw; i++) begin
          bus.dmem_rvalid = 1'($urandom);
          @(negedge clk);
          chk("req_held", {31'b0, bus.dmem_req}, 32'd1);
        end
        bus.dmem_rvalid = 1'b0;
        bus.dmem_gnt = 1'b1;
        bus.flush = fm == 3;
        @(negedge clk);
        bus.dmem_gnt = 1'b0;
        bus.flush = 1'b0;
        chk("req_dropped", {31'b0, bus.dmem_req}, 32'd0);
        if (fcn == 1) begin
          bus.flush = fm == 2;
          for (int i = 0; i < rw; i++) begin
            bus.dmem_gnt = 1'($urandom);
            @(negedge clk);
            bus.flush = 1'b0;
          end
          bus.dmem_gnt = 1'b0;
          chk("busy_wait", {31'b0, bus.ex_ready}, 32'd0);
          bus.dmem_rvalid = 1'b1;
          bus.dmem_rdata = rdata;
          @(negedge clk);
          bus.flush = 1'b0;
          bus.dmem_rvalid = 1'b0;
          bus.dmem_rdata = $urandom;
        end
      end
    end else if (mem) begin
      chk("trap_no_req", {31'b0, bus.dmem_req}, 32'd0);
    end
  endtask

  // monitor: every write-back pulse must match the oldest expectation, at the predicted cycle
  initial forever begin
    exp_t e;
    @(negedge clk);
    if (bus.wb_valid) begin
      if (q.size() == 0) chk("unexpected_wb", {31'b0, bus.wb_valid}, 32'd0);
      else begin
        e = q.pop_front();
        chk("wb_cycle", cyc, e.at);
        chk("wb_rd", {27'b0, bus.wb_rd}, {27'b0, e.rd});
        chk("wb_wen", {31'b0, bus.wb_wen}, {31'b0, e.wen});
        chk("wb_exc", {31'b0, bus.misalign_exc}, {31'b0, e.exc});
        if (e.dc) chk("wb_data", bus.wb_data, e.data);
      end
    end else if (bus.misalign_exc) chk("exc_without_wb", {31'b0, bus.misalign_exc}, 32'd0);
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] f;
    logic [2:0] t;
    int gw, rw, fm, r;
    bus.ex_valid = 1'b0;
    bus.flush = 1'b0;
    bus.alu_out = '0;
    bus.store_data = '0;
    bus.mem_fcn = 2'b00;
    bus.mem_typ = 3'b000;
    bus.rd_addr = '0;
    bus.rf_wen = 1'b0;
    bus.dmem_gnt = 1'b0;
    bus.dmem_rvalid = 1'b0;
    bus.dmem_rdata = '0;
    repeat (3) @(negedge clk);
    chk("rst_ready", {31'b0, bus.ex_ready}, 32'd1);
    chk("rst_req", {31'b0, bus.dmem_req}, 32'd0);
    chk("rst_we", {31'b0, bus.dmem_we}, 32'd0);
    chk("rst_addr", bus.dmem_addr, 32'd0);
    chk("rst_be", {28'b0, bus.dmem_be}, 32'd0);
    chk("rst_wdata", bus.dmem_wdata, 32'd0);
    chk("rst_wb_valid", {31'b0, bus.wb_valid}, 32'd0);
    chk("rst_wb_data", bus.wb_data, 32'd0);
    chk("rst_exc", {31'b0, bus.misalign_exc}, 32'd0);
    reset_n = 1'b1;
    @(negedge clk);
    do_op(2'b00, 3'b010, 32'h1234, 32'h0, 32'h0, 5'd5, 1'b1, 0, 0, 0);
    do_op(2'b01, 3'b000, 32'h103, 32'h0, 32'h80FF_0000, 5'd7, 1'b1, 0, 0, 0);
    do_op(2'b01, 3'b100, 32'h103, 32'h0, 32'h80FF_0000, 5'd8, 1'b1, 0, 0, 0);
    do_op(2'b10, 3'b001, 32'h202, 32'hABCD_1234, 32'h0, 5'd3, 1'b1, 3, 0, 0);
    do_op(2'b01, 3'b010, 32'h300, 32'h0, 32'hDEAD_BEEF, 5'd9, 1'b1, 0, 2, 2);
    do_op(2'b01, 3'b010, 32'h102, 32'h0, 32'h1122_3344, 5'd10, 1'b1, 1, 1, 0);
    do_op(2'b10, 3'b010, 32'h400, 32'h5555_AAAA, 32'h0, 5'd11, 1'b1, 2, 0, 1);
    do_op(2'b10, 3'b000, 32'h401, 32'h0000_00A5, 32'h0, 5'd12, 1'b1, 0, 0, 3);
    wait_ready();
    bus.ex_valid = 1'b1;
    bus.flush = 1'b1;
    bus.mem_fcn = 2'b00;
    @(negedge clk);
    bus.ex_valid = 1'b0;
    bus.flush = 1'b0;
    chk("idle_flush_blocks", {31'b0, bus.ex_ready}, 32'd1);
    bus.ex_valid = 1'b1;
    bus.mem_fcn = 2'b01;
    bus.mem_typ = 3'b010;
    bus.alu_out = 32'h500;
    @(negedge clk);
    bus.ex_valid = 1'b0;
    chk("pre_rst_req", {31'b0, bus.dmem_req}, 32'd1);
    reset_n = 1'b0;
    #1;
    chk("async_rst_req", {31'b0, bus.dmem_req}, 32'd0);
    chk("async_rst_ready", {31'b0, bus.ex_ready}, 32'd1);
    @(negedge clk);
    reset_n = 1'b1;
    bus.dmem_gnt = 1'b1;
    bus.dmem_rvalid = 1'b1;
    @(negedge clk);
    bus.dmem_gnt = 1'b0;
    bus.dmem_rvalid = 1'b0;
    chk("stale_ignored", {31'b0, bus.ex_ready}, 32'd1);
    do_op(2'b01, 3'b101, 32'h602, 32'h0, 32'h8001_7FFF, 5'd13, 1'b1, 1, 0, 0);
    for (int k = 0; k < 300; k++) begin
      f = 2'($urandom);
      t = 3'($urandom);
      gw = $urandom_range(0, 3);
      rw = $urandom_range(0, 3);
      r = $urandom_range(0, 7);
      fm = r < 5 ? 0 : r - 4;
      if (f == 2'b00 || f == 2'b11) fm = 0;
      if (fm == 2 && f != 2'b01) fm = 0;
`ifdef MEM_MISALIGN_TRAP_EN
      if (fm != 0) t = 3'b000;
`endif
      do_op(f, t, $urandom, $urandom, $urandom, 5'($urandom), 1'($urandom), gw, rw, fm);
    end
    repeat (10) @(negedge clk);
    chk("sb_empty", q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
